// File: rtl/predictor_update_sched.sv
// Branch-predictor update scheduler: queues updates and applies them in order to gshare/BTB/GHR.
// Optional `PR_SCHED_STATS_EN adds saturating applied-jump and fetch-stall counters.
module predictor_update_sched #(
  parameter int FIFO_DEPTH       = 4,
  parameter int GSH_SIZE         = 256,
  parameter int BTB_SIZE         = 256,
  parameter int GSH_HISTORY_BITS = 2,
  localparam int IDX             = $clog2(GSH_SIZE),
  localparam int BIDX            = $clog2(BTB_SIZE),
  localparam int H               = GSH_HISTORY_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd_valid_i,
  input  logic [71:0]     upd_i,
  input  logic            skip_btb_i,
  output logic            upd_ready_o,
  input  logic            fetch_rd_i,
  output logic            gsh_rd_en_o,
  output logic [IDX-1:0]  gsh_rd_idx_o,
  input  logic [1:0]      gsh_rd_cnt_i,
  output logic            gsh_wr_en_o,
  output logic [IDX-1:0]  gsh_wr_idx_o,
  output logic [1:0]      gsh_wr_cnt_o,
  output logic            btb_wr_en_o,
  output logic [BIDX-1:0] btb_wr_idx_o,
  output logic [31:0]     btb_wr_orig_pc_o,
  output logic [31:0]     btb_wr_target_o,
  output logic [H-1:0]    ghr_o,
  output logic            busy_o
`ifdef PR_SCHED_STATS_EN
  ,
  output logic [15:0]     upd_cnt_o,
  output logic [15:0]     stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 73;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t          state, state_n;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            push, pop;
  logic [EW-1:0]   head;
  logic            head_jump, head_taken, head_skip;
  logic [31:0]     head_pc, head_target;
  logic [IDX-1:0]  ghr_ext, rd_idx, wr_idx;
  logic [H-1:0]    ghr;
  logic            unused_bits;

  // Entry layout is {upd_i, skip_btb_i}; rat_id, ticket and is_comp ride along untouched.
  assign head        = mem[rd_ptr];
  assign head_jump   = head[72];
  assign head_taken  = head[71];
  assign head_pc     = head[67:36];
  assign head_target = head[35:4];
  assign head_skip   = head[0];
  assign unused_bits = ^{head[70:68], head[3:1]};

  assign upd_ready_o = (count < (PW+1)'(FIFO_DEPTH));
  assign push        = upd_valid_i && upd_ready_o;
  assign busy_o      = (count != '0) || (state != IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head_jump) state_n = RD;
          else           pop     = 1'b1;
        end
      end
      RD:      if (!fetch_rd_i) state_n = WR;
      WR: begin
        pop     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Enables are masked by rst so an update caught mid-flight never reaches the tables.
  assign ghr_ext      = IDX'(ghr);
  assign rd_idx       = head_pc[IDX+1:2] ^ ghr_ext;
  assign gsh_rd_en_o  = (state == RD) && !fetch_rd_i && !rst;
  assign gsh_rd_idx_o = rd_idx;
  assign gsh_wr_en_o  = (state == WR) && !rst;
  assign gsh_wr_idx_o = wr_idx;
  assign btb_wr_en_o  = (state == WR) && head_taken && !head_skip && !rst;
  assign btb_wr_idx_o = head_pc[BIDX+1:2];
  assign btb_wr_orig_pc_o = head_pc;
  assign btb_wr_target_o  = head_target;
  assign ghr_o        = ghr;

  always_comb begin
    gsh_wr_cnt_o = gsh_rd_cnt_i;
    if (head_taken) begin
      if (gsh_rd_cnt_i != 2'd3) gsh_wr_cnt_o = gsh_rd_cnt_i + 2'd1;
    end else begin
      if (gsh_rd_cnt_i != 2'd0) gsh_wr_cnt_o = gsh_rd_cnt_i - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {upd_i, skip_btb_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ghr    <= '0;
      wr_idx <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (gsh_rd_en_o) wr_idx <= rd_idx;
      if (state == WR) ghr <= {ghr[H-2:0], head_taken};
    end
  end

`ifdef PR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (state == WR && upd_cnt_o != 16'hFFFF) upd_cnt_o <= upd_cnt_o + 16'd1;
      if (state == RD && fetch_rd_i && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_predictor_update_sched.sv
// Table-driven bench with an in-order scoreboard for predictor_update_sched.
module tb_predictor_update_sched;

  logic        clk;
  logic        rst;
  logic        upd_valid_i;
  logic [71:0] upd_i;
  logic        skip_btb_i;
  logic        upd_ready_o;
  logic        fetch_rd_i;
  logic        gsh_rd_en_o;
  logic [7:0]  gsh_rd_idx_o;
  logic [1:0]  gsh_rd_cnt_i;
  logic        gsh_wr_en_o;
  logic [7:0]  gsh_wr_idx_o;
  logic [1:0]  gsh_wr_cnt_o;
  logic        btb_wr_en_o;
  logic [7:0]  btb_wr_idx_o;
  logic [31:0] btb_wr_orig_pc_o;
  logic [31:0] btb_wr_target_o;
  logic [1:0]  ghr_o;
  logic        busy_o;
`ifdef PR_SCHED_STATS_EN
  logic [15:0] upd_cnt_o;
  logic [15:0] stall_cnt_o;
`endif

  predictor_update_sched dut (
    .clk(clk), .rst(rst),
    .upd_valid_i(upd_valid_i), .upd_i(upd_i), .skip_btb_i(skip_btb_i),
    .upd_ready_o(upd_ready_o), .fetch_rd_i(fetch_rd_i),
    .gsh_rd_en_o(gsh_rd_en_o), .gsh_rd_idx_o(gsh_rd_idx_o), .gsh_rd_cnt_i(gsh_rd_cnt_i),
    .gsh_wr_en_o(gsh_wr_en_o), .gsh_wr_idx_o(gsh_wr_idx_o), .gsh_wr_cnt_o(gsh_wr_cnt_o),
    .btb_wr_en_o(btb_wr_en_o), .btb_wr_idx_o(btb_wr_idx_o),
    .btb_wr_orig_pc_o(btb_wr_orig_pc_o), .btb_wr_target_o(btb_wr_target_o),
    .ghr_o(ghr_o), .busy_o(busy_o)
`ifdef PR_SCHED_STATS_EN
    , .upd_cnt_o(upd_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vj;
    logic        jt;
    logic        skip;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  cnt;
    logic [7:0]  rd_idx;
    logic [1:0]  wr_cnt;
    logic        btb_en;
    logic [7:0]  btb_idx;
    logic [1:0]  ghr_after;
  } vec_t;

  vec_t tbl[7];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  bit   mon_en = 1'b1;
  bit   pend_ghr = 1'b0;
  logic [1:0] pend_ghr_val = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or never arrived at %0t", name, $time);
  endtask

  function automatic logic [71:0] mk(input vec_t v, input logic [2:0] tk);
    return {v.vj, v.jt, 1'b1, 2'b10, v.pc, v.tgt, tk};
  endfunction

  // Scoreboard: the head of exp_q is always the jump currently in RD/WR.
  initial begin
    forever begin
      @(negedge clk);
      if (pend_ghr) begin
        pend_ghr = 1'b0;
        chk("ghr_after", 64'(ghr_o), 64'(pend_ghr_val));
      end
      if (mon_en) begin
        if (gsh_rd_en_o) begin
          if (exp_q.size() == 0) fail_evt("unexpected_rd");
          else begin
            chk("rd_idx", 64'(gsh_rd_idx_o), 64'(exp_q[0].rd_idx));
            gsh_rd_cnt_i = exp_q[0].cnt;
          end
        end
        if (gsh_wr_en_o) begin
          if (exp_q.size() == 0) fail_evt("unexpected_wr");
          else begin
            vec_t e;
            e = exp_q.pop_front();
            chk("wr_idx", 64'(gsh_wr_idx_o), 64'(e.rd_idx));
            chk("wr_cnt", 64'(gsh_wr_cnt_o), 64'(e.wr_cnt));
            chk("btb_en", 64'(btb_wr_en_o), 64'(e.btb_en));
            if (e.btb_en) begin
              chk("btb_idx", 64'(btb_wr_idx_o), 64'(e.btb_idx));
              chk("btb_pc", 64'(btb_wr_orig_pc_o), 64'(e.pc));
              chk("btb_tgt", 64'(btb_wr_target_o), 64'(e.tgt));
            end
            pend_ghr     = 1'b1;
            pend_ghr_val = e.ghr_after;
            wr_seen++;
          end
        end else if (btb_wr_en_o) fail_evt("btb_without_gsh");
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    upd_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    pend_ghr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic push_vec(input vec_t v, input logic [2:0] tk, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    upd_valid_i = 1'b1;
    upd_i = mk(v, tk);
    skip_btb_i = v.skip;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      if (upd_ready_o) begin
        acc = 1'b1;
        if (v.vj) exp_q.push_back(v);
      end else waited++;
      @(posedge clk);
      #1;
    end
    upd_valid_i = 1'b0;
    if (!acc) fail_evt("push_timeout");
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0 && !pend_ghr) done = 1'b1;
    end
    if (!done) fail_evt("drain_timeout");
  endtask

  initial begin #400000; $display("FAIL global_timeout"); $fatal(1); end

  initial begin
    int  w;
    bit  found;
    //          vj   jt   skip pc            tgt           cnt   rd_idx wr_cnt btb  btb_idx ghr
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 2'd1, 8'h40, 2'd2, 1'b1, 8'h40, 2'b01};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0300, 2'd0, 8'h40, 2'd0, 1'b0, 8'h41, 2'b10};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 2'd0, 8'h00, 2'd0, 1'b0, 8'h40, 2'b10};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0208, 32'h0000_0400, 2'd3, 8'h80, 2'd3, 1'b0, 8'h82, 2'b01};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_03FC, 32'h0000_0000, 2'd2, 8'hFE, 2'd1, 1'b0, 8'hFF, 2'b10};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_1234, 32'hDEAD_BEE0, 2'd0, 8'h8F, 2'd1, 1'b1, 8'h8D, 2'b01};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, 2'd1, 8'h05, 2'd0, 1'b0, 8'h04, 2'b10};

    rst = 1'b1; upd_valid_i = 1'b0; upd_i = '0; skip_btb_i = 1'b0;
    fetch_rd_i = 1'b0; gsh_rd_cnt_i = 2'd0;

    do_reset();
    @(negedge clk);
    chk("rst_ready", 64'(upd_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rd_en", 64'(gsh_rd_en_o), 64'd0);
    chk("rst_wr_en", 64'(gsh_wr_en_o), 64'd0);
    chk("rst_btb_en", 64'(btb_wr_en_o), 64'd0);
    chk("rst_ghr", 64'(ghr_o), 64'd0);
    @(posedge clk); #1;

    // Whole table back-to-back, fetch never blocking.
    for (int i = 0; i < 7; i++) push_vec(tbl[i], 3'(i), w);
    wait_idle();
`ifdef PR_SCHED_STATS_EN
    chk("upd_cnt_table", 64'(upd_cnt_o), 64'd6);
    chk("stall_cnt_table", 64'(stall_cnt_o), 64'd0);
`endif

    // Fetch holds the read port three RD cycles.
    do_reset();
    fetch_rd_i = 1'b1;
    push_vec(tbl[0], 3'd0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_en_stalled", 64'(gsh_rd_en_o), 64'd0);
      @(posedge clk); #1;
    end
    fetch_rd_i = 1'b0;
    @(negedge clk);
    chk("rd_en_released", 64'(gsh_rd_en_o), 64'd1);
    @(posedge clk); #1;
    wait_idle();
`ifdef PR_SCHED_STATS_EN
    chk("stall_cnt", 64'(stall_cnt_o), 64'd3);
    chk("upd_cnt_one", 64'(upd_cnt_o), 64'd1);
`endif

    // Fill the queue while RD is stalled; fifth update waits for the first WR pop.
    do_reset();
    wr_seen = 0;
    fetch_rd_i = 1'b1;
    push_vec(tbl[0], 3'd0, w);
    push_vec(tbl[1], 3'd1, w);
    push_vec(tbl[3], 3'd3, w);
    push_vec(tbl[4], 3'd4, w);
    @(negedge clk);
    chk("full_ready", 64'(upd_ready_o), 64'd0);
    @(posedge clk); #1;
    fork
      push_vec(tbl[5], 3'd5, w);
      begin
        repeat (3) @(posedge clk);
        #1 fetch_rd_i = 1'b0;
      end
    join
    chk("fifth_wait_cycles", 64'(w), 64'd5);
    chk("fifth_after_wr", 64'(wr_seen), 64'd1);
    wait_idle();

    // Reset landing in WR aborts the write and discards the queue.
    do_reset();
    mon_en = 1'b0;
    fetch_rd_i = 1'b1;
    push_vec(tbl[0], 3'd0, w);
    push_vec(tbl[1], 3'd1, w);
    exp_q.delete();
    fetch_rd_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (gsh_rd_en_o) found = 1'b1;
    end
    if (!found) fail_evt("rd_before_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr_gsh_en", 64'(gsh_wr_en_o), 64'd0);
    chk("rstwr_btb_en", 64'(btb_wr_en_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr_busy", 64'(busy_o), 64'd0);
    chk("rstwr_ready", 64'(upd_ready_o), 64'd1);
    chk("rstwr_ghr", 64'(ghr_o), 64'd0);
    mon_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/predictor_update_sched.md
PREDICTOR_UPDATE_SCHED -- requirements
Module: predictor_update_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning update-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter GSH_SIZE, default 256, meaning gshare 2-bit counter entries (IDX = log2 GSH_SIZE).
REQ-003 SHALL have parameter BTB_SIZE, default 256, meaning BTB entries (BIDX = log2 BTB_SIZE).
REQ-004 SHALL have parameter GSH_HISTORY_BITS, default 2, meaning global history register width H.
REQ-005 SHALL have ports, one per line:
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous, active-high reset
 upd_valid_i  in  1  predictor update offered
 upd_i  in  72  predictor_update {valid_jump, jump_taken, is_comp, rat_id[1:0], orig_pc[31:0], jump_address[31:0], ticket[2:0]}
 skip_btb_i  in  1  suppress BTB write for this update
 upd_ready_o  out  1  queue can accept
 fetch_rd_i  in  1  fetch owns gshare read port this cycle
 gsh_rd_en_o  out  1  gshare read request
 gsh_rd_idx_o  out  IDX  gshare read index
 gsh_rd_cnt_i  in  2  counter value, valid cycle after gsh_rd_en_o
 gsh_wr_en_o  out  1  gshare write
 gsh_wr_idx_o  out  IDX  gshare write index
 gsh_wr_cnt_o  out  2  new counter value
 btb_wr_en_o  out  1  BTB write
 btb_wr_idx_o  out  BIDX  BTB index
 btb_wr_orig_pc_o  out  32  BTB tag PC
 btb_wr_target_o  out  32  BTB target
 ghr_o  out  H  global history
 busy_o  out  1  queue non-empty or FSM not IDLE

Function
REQ-006 SHALL store {upd_i, skip_btb_i} in a FIFO on upd_valid_i && upd_ready_o; upd_ready_o = (count < FIFO_DEPTH), from registered count only (no same-cycle pop bypass).
REQ-007 SHALL allow push and pop in the same cycle; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-008 SHALL implement FSM states IDLE, RD, WR.
REQ-009 IDLE: head with valid_jump=0 SHALL be popped in that cycle with no table access, stay IDLE; head with valid_jump=1 -> RD; empty -> IDLE.
REQ-010 RD: SHALL assert gsh_rd_en_o with index only when fetch_rd_i=0, then -> WR; fetch_rd_i=1 SHALL hold RD with gsh_rd_en_o=0.
REQ-011 Gshare index SHALL be orig_pc[IDX+1:2] XOR zero-extended ghr, computed with ghr at RD issue.
REQ-012 WR: SHALL assert gsh_wr_en_o at same index, gsh_wr_cnt_o = jump_taken ? sat(cnt+1, max 3) : sat(cnt-1, min 0); pop head; ghr <= {ghr[H-2:0], jump_taken}; -> IDLE.
REQ-013 WR: SHALL assert btb_wr_en_o iff jump_taken && !skip_btb; idx = orig_pc[BIDX+1:2], orig_pc and jump_address driven out.
REQ-014 Updates SHALL be applied strictly in arrival order; minimum 1 cycle per non-jump, 3 cycles (IDLE, RD, WR) per jump.
REQ-015 All outputs except upd_ready_o and busy_o SHALL be registered-state decodes with no combinational path from upd_i.
REQ-016 rat_id, ticket, is_comp SHALL be carried but not used.

Reset
REQ-017 rst=1 SHALL empty FIFO, ghr=0, FSM=IDLE, all *_en_o=0, busy_o=0, upd_ready_o=1 on the following cycle.
REQ-018 rst mid-operation (RD or WR) SHALL abort without issuing the pending write; queued updates are discarded.

Configuration
REQ-019 With PR_SCHED_STATS_EN defined, SHALL add outputs upd_cnt_o[15:0] (jump updates applied, +1 per WR) and stall_cnt_o[15:0] (RD cycles blocked by fetch_rd_i), both saturating at 16'hFFFF, reset to 0.
REQ-020 Without PR_SCHED_STATS_EN, those ports and counters SHALL be absent; other behaviour identical.

Verification
REQ-021 Reset, then push jump orig_pc=0x100, taken, target 0x200, gsh_rd_cnt_i=1 -> gshare rd idx 0x40, wr cnt 2, btb_wr idx 0x40 target 0x200, ghr_o=2'b01.
REQ-022 Push not-taken jump with cnt=0 -> gsh_wr_cnt_o=0, btb_wr_en_o=0, ghr shifts in 0.
REQ-023 Push 5 updates back-to-back with FSM stalled (fetch_rd_i=1) -> upd_ready_o=0 after 4th accept; 5th held until first WR pop.
REQ-024 fetch_rd_i high 3 cycles in RD -> gsh_rd_en_o delayed 3 cycles; stall_cnt_o=3 with PR_SCHED_STATS_EN.
REQ-025 Taken jump with skip_btb_i=1 -> gshare updated, btb_wr_en_o=0; rst asserted in WR -> no write, busy_o=0 next cycle.
